mem_access_ctrl: RTL

- Sequences the MEM pipeline stage against a data memory that uses a req/ack handshake.
- Freezes the upstream stage registers (IF..MEM) while an access is outstanding.
- Presents load data plus a one-cycle valid to the WB stage register; the valid de-asserts to insert a bubble.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for a req/ack data memory: freezes upstream stages, hands load data to WB.
// Optional MEM_TIMEOUT_EN macro adds a REQ wait limit with a sticky timeout_err flag.
module mem_access_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_is_store,
  input  logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic                  flush,
  input  logic                  dmem_ack,
  input  logic [WORD_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_WIDTH-1:0] dmem_addr,
  output logic [WORD_WIDTH-1:0] dmem_wdata,
  output logic                  stall_pipe,
  output logic                  wb_valid,
  output logic [WORD_WIDTH-1:0] wb_rdata,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                  state_q;
  logic                    req_q;
  logic                    we_q;
  logic [WORD_WIDTH-1:0]   addr_q;
  logic [WORD_WIDTH-1:0]   wdata_q;
  logic [WORD_WIDTH-1:0]   rdata_q;
  logic                    wb_valid_q;
  logic                    flushed_q;
  logic [CNT_WIDTH-1:0]    stall_cnt_q;
  logic                    tmo_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_err_q;

  assign tmo_hit     = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;
`else
  // REQ waits indefinitely; the compare only keeps TIMEOUT referenced
  assign tmo_hit     = (TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

  assign stall_pipe   = ((state_q == IDLE) && mem_valid && !flush) || (state_q == REQ);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_rdata     = rdata_q;
  assign stall_cycles = stall_cnt_q;
  // a flush arriving in DONE still squashes the retiring result
  assign wb_valid     = wb_valid_q && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      wb_valid_q    <= 1'b0;
      flushed_q     <= 1'b0;
      stall_cnt_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      if (stall_pipe && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);

      case (state_q)
        IDLE: begin
          if (mem_valid && !flush) begin
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            we_q      <= mem_is_store;
            req_q     <= 1'b1;
            flushed_q <= 1'b0;
            state_q   <= REQ;
`ifdef MEM_TIMEOUT_EN
            wait_q    <= '0;
`endif
          end
        end
        REQ: begin
          if (flush)
            flushed_q <= 1'b1;
          // ack beats a coincident timeout
          if (dmem_ack) begin
            if (!we_q)
              rdata_q <= dmem_rdata;
            req_q      <= 1'b0;
            wb_valid_q <= !(flushed_q || flush);
            state_q    <= DONE;
          end else if (tmo_hit) begin
            req_q   <= 1'b0;
            state_q <= DONE;
`ifdef MEM_TIMEOUT_EN
            timeout_err_q <= 1'b1;
`endif
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
`endif
        end
        DONE: begin
          flushed_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
